// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous-read program/data memory between
// the processor and the loader/debug port, with stall, halt and tagged read return.
module mem_port_arbiter #(
  parameter int LD_BURST_MAX = 4,
  parameter int LD_PRIORITY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_adr,
  input  logic [7:0]  cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [14:0] cpu_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [7:0]  ld_adr,
  input  logic [14:0] ld_wd,
  input  logic        ld_halt,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [14:0] ld_rdata,
  output logic        halted,
  output logic        mem_we,
  output logic [7:0]  mem_adr,
  output logic [14:0] mem_wd,
  input  logic [14:0] mem_rd
);

  typedef enum logic {WIN_CPU = 1'b0, WIN_LD = 1'b1} winner_t;

  localparam logic [3:0] BURST_MAX = 4'(LD_BURST_MAX);

  winner_t     last_winner;
  logic [3:0]  burst_cnt;
  logic [7:0]  adr_q;
  logic [14:0] wd_q;
  logic        pend_valid;
  winner_t     pend_owner;
  logic [14:0] cpu_rdata_q;
  logic [14:0] ld_rdata_q;

  logic cpu_elig;
  logic ld_elig;
  logic ld_wins;

  // Eligibility is gated by reset so every grant-derived output is 0 in reset.
  always_comb begin
    cpu_elig = reset & cpu_req & ~ld_halt;
    ld_elig  = reset & ld_req;
    ld_wins  = ld_elig;
    if (cpu_elig && ld_elig) begin
      if (LD_PRIORITY != 0 && burst_cnt < BURST_MAX)
        ld_wins = 1'b1;
      else
        ld_wins = (last_winner == WIN_CPU);
    end
  end

  assign ld_gnt    = ld_wins;
  assign cpu_gnt   = cpu_elig & ~ld_wins;
  assign cpu_stall = reset & cpu_req & ~cpu_gnt;

  // With no grant the bus replays the last driven address/data instead of toggling.
  assign mem_we  = (ld_gnt & ld_we) | (cpu_gnt & cpu_we);
  assign mem_adr = ld_gnt ? ld_adr : (cpu_gnt ? cpu_adr : adr_q);
  assign mem_wd  = ld_gnt ? ld_wd  : (cpu_gnt ? {7'd0, cpu_wd} : wd_q);

  assign cpu_rvalid = reset & pend_valid & (pend_owner == WIN_CPU);
  assign ld_rvalid  = reset & pend_valid & (pend_owner == WIN_LD);
  assign cpu_rdata  = cpu_rvalid ? mem_rd : cpu_rdata_q;
  assign ld_rdata   = ld_rvalid  ? mem_rd : ld_rdata_q;

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the bus-hold and read-data registers are cleared too; they are a
      // handful of flops, not a memory, and a known value keeps outputs defined.
      last_winner <= WIN_LD;
      burst_cnt   <= 4'd0;
      adr_q       <= 8'd0;
      wd_q        <= 15'd0;
      pend_valid  <= 1'b0;
      pend_owner  <= WIN_CPU;
      cpu_rdata_q <= 15'd0;
      ld_rdata_q  <= 15'd0;
      halted      <= 1'b0;
    end else begin
      halted <= ld_halt;

      if (cpu_gnt || ld_gnt) begin
        last_winner <= ld_gnt ? WIN_LD : WIN_CPU;
        adr_q       <= mem_adr;
        wd_q        <= mem_wd;
      end

      if (cpu_gnt || !cpu_req)
        burst_cnt <= 4'd0;
      else if (ld_gnt && burst_cnt < BURST_MAX)
        burst_cnt <= burst_cnt + 4'd1;

      pend_valid <= (cpu_gnt || ld_gnt) && !mem_we;
      pend_owner <= ld_gnt ? WIN_LD : WIN_CPU;

      if (cpu_rvalid) cpu_rdata_q <= mem_rd;
      if (ld_rvalid)  ld_rdata_q  <= mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level reference model and a model memory.
module tb_mem_port_arbiter;

  localparam int LD_BURST_MAX = 4;
  localparam int LD_PRIORITY  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_adr, cpu_wd;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [14:0] cpu_rdata;
  logic        ld_req, ld_we, ld_halt;
  logic [7:0]  ld_adr;
  logic [14:0] ld_wd;
  logic        ld_gnt, ld_rvalid;
  logic [14:0] ld_rdata;
  logic        halted;
  logic        mem_we;
  logic [7:0]  mem_adr;
  logic [14:0] mem_wd;
  logic [14:0] mem_rd;

  mem_port_arbiter #(.LD_BURST_MAX(LD_BURST_MAX), .LD_PRIORITY(LD_PRIORITY)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wd(ld_wd), .ld_halt(ld_halt),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .halted(halted),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the arbiter's bus.
  logic [14:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_adr] <= mem_wd;
    mem_rd <= tb_mem[mem_adr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, expressed as transactions rather than flops.
  logic [14:0] ref_mem [256];
  bit          m_init;
  int          m_burst;
  bit          m_last_cpu;
  bit          m_pend;
  bit          m_pend_ld;
  logic [14:0] m_pend_data;
  logic [14:0] m_cpu_rd, m_ld_rd;
  logic [7:0]  m_adr;
  logic [14:0] m_wd;
  bit          m_halted;
  bit          obs_ld_gnt;

  task automatic cycle(input bit rst, input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit lr, input bit lw,
                       input logic [7:0] la, input logic [14:0] ld, input bit h);
    bit e_cg, e_lg, ce, le, g, g_we, rv_cpu, rv_ld;
    logic [7:0]  g_adr;
    logic [14:0] g_wd;
    reset = rst; cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wd = cd;
    ld_req = lr; ld_we = lw; ld_adr = la; ld_wd = ld; ld_halt = h;
    #1;
    ce = rst && cr && !h;
    le = rst && lr;
    if (ce && le)
      e_lg = (LD_PRIORITY == 1 && m_burst < LD_BURST_MAX) ? 1'b1 : m_last_cpu;
    else
      e_lg = le;
    e_cg  = ce && !e_lg;
    g     = e_cg || e_lg;
    g_we  = g && (e_lg ? lw : cw);
    g_adr = e_lg ? la : ca;
    g_wd  = e_lg ? ld : {7'd0, cd};
    rv_cpu = rst && m_pend && !m_pend_ld;
    rv_ld  = rst && m_pend && m_pend_ld;

    check("cpu_gnt", cpu_gnt, e_cg);
    check("ld_gnt", ld_gnt, e_lg);
    check("cpu_stall", cpu_stall, rst && cr && !e_cg);
    check("mem_we", mem_we, g_we);
    if (m_init || g) begin
      check("mem_adr", mem_adr, g ? g_adr : m_adr);
      check("mem_wd", mem_wd, g ? g_wd : m_wd);
    end
    if (m_init) begin
      check("cpu_rvalid", cpu_rvalid, rv_cpu);
      check("ld_rvalid", ld_rvalid, rv_ld);
      check("cpu_rdata", cpu_rdata, rv_cpu ? m_pend_data : m_cpu_rd);
      check("ld_rdata", ld_rdata, rv_ld ? m_pend_data : m_ld_rd);
      check("halted", halted, m_halted);
    end
    obs_ld_gnt = ld_gnt;

    @(posedge clk);
    if (!rst) begin
      m_init = 1; m_burst = 0; m_last_cpu = 0; m_pend = 0; m_pend_ld = 0;
      m_cpu_rd = '0; m_ld_rd = '0; m_adr = '0; m_wd = '0; m_halted = 0;
    end else begin
      if (rv_cpu) m_cpu_rd = m_pend_data;
      if (rv_ld)  m_ld_rd  = m_pend_data;
      m_pend = g && !g_we;
      m_pend_ld = e_lg;
      if (g) begin
        m_pend_data = ref_mem[g_adr];
        if (g_we) ref_mem[g_adr] = g_wd;
        m_adr = g_adr; m_wd = g_wd; m_last_cpu = e_cg;
      end
      if (e_cg || !cr) m_burst = 0;
      else if (e_lg && m_burst < LD_BURST_MAX) m_burst++;
      m_halted = h;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 15'h0, 0);
  endtask

  logic [9:0] pat;
  bit         rh;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 15'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[0] = 15'h1234; tb_mem[1] = 15'h0567; tb_mem[2] = 15'h7FFF;
    ref_mem[0] = 15'h1234; ref_mem[1] = 15'h0567; ref_mem[2] = 15'h7FFF;
    m_init = 0; m_burst = 0; m_last_cpu = 0; m_pend = 0; m_pend_ld = 0;
    m_pend_data = '0; m_cpu_rd = '0; m_ld_rd = '0; m_adr = '0; m_wd = '0; m_halted = 0;
    @(negedge clk);

    // Reset held with both requesters active.
    repeat (3) cycle(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 15'h0, 0);
    check("rst_halted", halted, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    cycle(1, 1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 15'h0, 0);
    idle();

    // CPU-only reads of the preloaded words.
    cycle(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    check("rd0_data", cpu_rdata, 15'h1234);
    cycle(1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    check("rd1_data", cpu_rdata, 15'h0567);
    cycle(1, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    check("rd2_data", cpu_rdata, 15'h7FFF);
    check("rd2_ldv", ld_rvalid, 0);
    idle();

    // Continuous contention: loader bursts of four, then one CPU slot.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 8'(i), 8'h00, 1, 0, 8'(i + 8), 15'h0, 0);
      pat = {pat[8:0], obs_ld_gnt};
    end
    check("burst_pat", pat, 10'b1111011110);
    idle();

    // Loader writes while the CPU is halted, then the CPU reads it back.
    cycle(1, 1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 15'h3FFF, 1);
    check("halt_taken", halted, 1);
    cycle(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    check("halt_rd_v", cpu_rvalid, 1);
    check("halt_rd_d", cpu_rdata, 15'h3FFF);
    idle();

    // CPU write: zero-extended data, no read return.
    cycle(1, 1, 1, 8'h20, 8'hA5, 0, 0, 8'h00, 15'h0, 0);
    check("wr_no_rv", cpu_rvalid, 0);
    idle();

    // Read in flight is dropped by reset.
    cycle(1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    cycle(0, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 15'h0, 0);
    check("rst_drop_rv", cpu_rvalid, 0);
    check("rst_drop_h", halted, 0);
    idle();

    // Random traffic over a small address window.
    rh = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) rh = ~rh;
      cycle($urandom_range(0, 59) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            8'($urandom_range(0, 15)), 15'($urandom), rh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
